// File: rtl/hdpldadapt_avmm_pkg.sv
// rtl/hdpldadapt_avmm_pkg.sv - shared constants and types for the AVMM read-data serializer
package hdpldadapt_avmm_pkg;

  localparam int NBEATS = 8;
  localparam int BEAT_W = $clog2(NBEATS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/hdpldadapt_avmm_sfifo.sv
// rtl/hdpldadapt_avmm_sfifo.sv - single-clock word queue with push/pop/full/empty/count
module hdpldadapt_avmm_sfifo #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          srst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = push & ~full;
  assign rd_ok = pop & ~empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at 2**AW; count carries the extra bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end
  end

endmodule

// File: rtl/hdpldadapt_avmm_rdata_ser.sv
// rtl/hdpldadapt_avmm_rdata_ser.sv - queues read-response words and serializes them LSB beat first
module hdpldadapt_avmm_rdata_ser
  import hdpldadapt_avmm_pkg::*;
#(
  parameter int DWIDTH = 2,
  parameter int QAW    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       srst_n,
  input  logic                       rdata_valid,
  input  logic [NBEATS*DWIDTH-1:0]   rdata,
  output logic                       rdata_ready,
  input  logic                       tx_stall,
  output logic                       tx_en,
  output logic [DWIDTH-1:0]          tx_data,
  output logic                       busy,
  output logic                       q_overflow
);

  localparam int WW = NBEATS * DWIDTH;

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat;
  logic [WW-1:0]     shreg;
  logic [WW-1:0]     q_rdata;
  logic [QAW:0]      q_count;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic              last_beat;

  assign rdata_ready = ~q_full;
  assign q_push      = rdata_valid & rdata_ready;
  assign last_beat   = (beat == BEAT_W'(NBEATS - 1));
  assign busy        = (q_count != '0) | (state == SHIFT);

  hdpldadapt_avmm_sfifo #(
    .W  (WW),
    .AW (QAW)
  ) u_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .srst_n (srst_n),
    .push   (q_push),
    .wdata  (rdata),
    .pop    (q_pop),
    .rdata  (q_rdata),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (!srst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The next word is popped on the last unstalled beat so consecutive words have no bubble.
  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!tx_stall && last_beat) begin
          if (!q_empty) begin
            q_pop = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      beat       <= '0;
      tx_en      <= 1'b0;
      tx_data    <= '0;
      q_overflow <= 1'b0;
    end else if (!srst_n) begin
      shreg      <= '0;
      beat       <= '0;
      tx_en      <= 1'b0;
      tx_data    <= '0;
      q_overflow <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      if (state == SHIFT && !tx_stall) begin
        tx_en   <= 1'b1;
        tx_data <= shreg[DWIDTH-1:0];
        shreg   <= shreg >> DWIDTH;
        beat    <= beat + 1'b1;
      end
      if (q_pop) begin
        shreg <= q_rdata;
        beat  <= '0;
      end
      if (rdata_valid && !rdata_ready) begin
        q_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdpldadapt_avmm_rdata_ser.sv
// tb/tb_hdpldadapt_avmm_rdata_ser.sv - self-checking bench for the read-data serializer
module tb_hdpldadapt_avmm_rdata_ser;

  localparam int DW  = 2;
  localparam int QAW = 2;
  localparam int NB  = 8;
  localparam int WW  = NB * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          srst_n = 1'b1;
  logic          rdata_valid = 1'b0;
  logic [WW-1:0] rdata = '0;
  logic          tx_stall = 1'b0;
  logic          rdata_ready;
  logic          tx_en;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          q_overflow;

  int checks = 0;
  int errors = 0;
  int got[$];
  int exp_q[$];

  hdpldadapt_avmm_rdata_ser #(
    .DWIDTH (DW),
    .QAW    (QAW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .srst_n      (srst_n),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .tx_stall    (tx_stall),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .busy        (busy),
    .q_overflow  (q_overflow)
  );

  always #5 clk = ~clk;

  // Reference: a word is NB base-4 digits, least significant digit sent first.
  function automatic void add_word(input logic [WW-1:0] w);
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back((int'(w) / (1 << (DW * i))) % (1 << DW));
    end
  endfunction

  task automatic collect(input int n, input int budget, output bit timed_out);
    int c;
    c = 0;
    timed_out = 1'b0;
    while (got.size() < n) begin
      @(negedge clk);
      if (tx_en) got.push_back(int'(tx_data));
      c++;
      if (got.size() < n && c >= budget) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; rdata_valid = 1'b1; rdata = 16'hA5A5;
    repeat (3) @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (q_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", q_overflow); end
    checks++; if (rdata_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdata_ready); end
    rdata_valid = 1'b0; rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (tx_en || busy) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_nothing_accepted: active cycles %0d want 0", seen); end
    rdata = 16'h1234; rdata_valid = 1'b1;
    @(negedge clk); rdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL async_pre_tx_en: got %b want 1", tx_en); end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL async_tx_en: got %b want 0", tx_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single(input logic [WW-1:0] w);
    bit to;
    got.delete(); exp_q.delete(); add_word(w);
    @(negedge clk); rdata = w; rdata_valid = 1'b1;
    @(negedge clk); rdata_valid = 1'b0;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_lat_e0: tx_en %b want 0", tx_en); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_lat_e1: tx_en %b want 0", tx_en); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_lat_e2: tx_en %b busy %b want 1 1", tx_en, busy); end
    if (tx_en) got.push_back(int'(tx_data));
    collect(NB, 20, to);
    checks++; if (to || got.size() != NB) begin errors++; $display("FAIL single_len: got %0d beats want %0d", got.size(), NB); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin errors++; $display("FAIL single_beat[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_en !== 1'b0) begin errors++; $display("FAIL single_end: busy %b tx_en %b want 0 0", busy, tx_en); end
  endtask

  task automatic test_back_to_back(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    int gaps;
    bit started;
    got.delete(); exp_q.delete(); add_word(w0); add_word(w1);
    gaps = 0; started = 1'b0;
    @(negedge clk); rdata = w0; rdata_valid = 1'b1;
    @(negedge clk); rdata = w1;
    @(negedge clk); rdata_valid = 1'b0;
    for (int c = 0; c < 40 && got.size() < 2 * NB; c++) begin
      @(negedge clk);
      if (tx_en) begin got.push_back(int'(tx_data)); started = 1'b1; end
      else if (started) gaps++;
    end
    checks++; if (got.size() != 2 * NB) begin errors++; $display("FAIL b2b_len: got %0d beats want %0d", got.size(), 2 * NB); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want 0", gaps); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin errors++; $display("FAIL b2b_beat[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: tx_en %b busy %b want 0 0", tx_en, busy); end
  endtask

  task automatic test_stall(input logic [WW-1:0] w);
    int gaps;
    int k;
    got.delete(); exp_q.delete(); add_word(w);
    gaps = 0; k = -1;
    @(negedge clk); rdata = w; rdata_valid = 1'b1;
    @(negedge clk); rdata_valid = 1'b0;
    for (int c = 0; c < 60 && got.size() < NB; c++) begin
      @(negedge clk);
      if (tx_en) got.push_back(int'(tx_data));
      else if (got.size() > 0) gaps++;
      if (k >= 0) begin
        k++;
        if (k == 4) tx_stall = 1'b0;
      end else if (got.size() == 4) begin
        tx_stall = 1'b1;
        k = 0;
      end
    end
    tx_stall = 1'b0;
    checks++; if (got.size() != NB) begin errors++; $display("FAIL stall_len: got %0d beats want %0d", got.size(), NB); end
    checks++; if (gaps != 4) begin errors++; $display("FAIL stall_gap: got %0d low cycles want 4", gaps); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin errors++; $display("FAIL stall_beat[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL stall_extra: tx_en %b want 0", tx_en); end
  endtask

  // One word moves straight into the shift register, so 5 fit before the queue reports full.
  task automatic test_overflow();
    logic [WW-1:0] w;
    bit to;
    got.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_stall = 1'b1;
      checks++;
      if (rdata_ready !== (i < 5 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL ovf_ready[%0d]: got %b want %b", i, rdata_ready, (i < 5 ? 1'b1 : 1'b0));
      end
      w = 16'($urandom);
      rdata = w; rdata_valid = 1'b1;
      if (i < 5) add_word(w);
    end
    @(negedge clk); rdata_valid = 1'b0;
    checks++; if (q_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", q_overflow); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL ovf_stalled: tx_en %b want 0", tx_en); end
    repeat (3) @(negedge clk);
    checks++; if (q_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", q_overflow); end
    tx_stall = 1'b0;
    collect(5 * NB, 100, to);
    checks++; if (to || got.size() != 5 * NB) begin errors++; $display("FAIL ovf_len: got %0d beats want %0d", got.size(), 5 * NB); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin errors++; $display("FAIL ovf_beat[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || q_overflow !== 1'b1) begin errors++; $display("FAIL ovf_end: busy %b ovf %b want 0 1", busy, q_overflow); end
  endtask

  task automatic test_srst();
    bit to;
    int seen;
    got.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rdata = 16'($urandom); rdata_valid = 1'b1;
    end
    @(negedge clk); rdata_valid = 1'b0;
    collect(6, 30, to);
    checks++; if (to) begin errors++; $display("FAIL srst_reach_beat5: got %0d beats want 6", got.size()); end
    srst_n = 1'b0;
    @(negedge clk); srst_n = 1'b1;
    checks++; if (tx_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL srst_clear: tx_en %b busy %b want 0 0", tx_en, busy); end
    checks++; if (rdata_ready !== 1'b1 || q_overflow !== 1'b0) begin errors++; $display("FAIL srst_queue: ready %b ovf %b want 1 0", rdata_ready, q_overflow); end
    seen = 0;
    repeat (10) begin @(negedge clk); if (tx_en || busy) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL srst_discard: active cycles %0d want 0", seen); end
    got.delete(); exp_q.delete(); add_word(16'h00FF);
    rdata = 16'h00FF; rdata_valid = 1'b1;
    @(negedge clk); rdata_valid = 1'b0;
    collect(NB, 20, to);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin errors++; $display("FAIL srst_beat[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    seen = 0;
    repeat (4) begin @(negedge clk); if (tx_en) seen++; end
    checks++; if (to || got.size() != NB || seen != 0) begin errors++; $display("FAIL srst_len: got %0d+%0d beats want %0d", got.size(), seen, NB); end
  endtask

  task automatic test_random(input int n);
    logic [WW-1:0] w;
    int acc;
    got.delete(); exp_q.delete();
    acc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (tx_en) got.push_back(int'(tx_data));
      if (acc == n && got.size() == NB * n) break;
      if (acc < n && rdata_ready && $urandom_range(1, 0) == 1) begin
        w = 16'($urandom);
        rdata = w; rdata_valid = 1'b1;
        add_word(w);
        acc++;
      end else begin
        rdata_valid = 1'b0;
      end
      tx_stall = ($urandom_range(9, 0) < 3);
    end
    rdata_valid = 1'b0; tx_stall = 1'b0;
    checks++; if (got.size() != NB * n) begin errors++; $display("FAIL rand_len: got %0d beats want %0d", got.size(), NB * n); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] != exp_q[i]) begin errors++; $display("FAIL rand_beat[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    checks++; if (q_overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf: got %b want 0", q_overflow); end
  endtask

  initial begin
    test_reset();
    test_single(16'h1BE4);
    test_back_to_back(16'h1BE4, 16'hFFFF);
    test_back_to_back(16'($urandom), 16'($urandom));
    test_stall(16'h1BE4);
    test_stall(16'($urandom));
    test_overflow();
    test_srst();
    test_random(24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
